// File: rtl/accumulator_bank.sv
// Row-wide accumulator bank: 3-stage write/accumulate pipeline with result forwarding,
// plus a two-stage read port. Define ACC_SATURATE_EN for signed saturating adds and sat_flag.
module accumulator_bank #(
   parameter int MATRIX_WIDTH   = 14,
   parameter int REGISTER_DEPTH = 512,
   parameter int WORD_WIDTH     = 32,
   parameter int ADDR_WIDTH     = $clog2(REGISTER_DEPTH)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enable,
   input  logic                                wr_en,
   input  logic [ADDR_WIDTH-1:0]               wr_addr,
   input  logic                                accumulate,
   input  logic [MATRIX_WIDTH*WORD_WIDTH-1:0]  data_in,
   input  logic                                rd_en,
   input  logic [ADDR_WIDTH-1:0]               rd_addr,
   output logic [MATRIX_WIDTH*WORD_WIDTH-1:0]  data_out,
   output logic                                rd_valid,
   output logic                                sat_flag
);

   localparam int ROW_WIDTH = MATRIX_WIDTH * WORD_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(REGISTER_DEPTH);

   logic [ROW_WIDTH-1:0] mem [REGISTER_DEPTH];

   // Write pipeline: S1 request + registered array read, S2 computed sum, S3 last commit.
   logic                  s1_valid, s1_acc;
   logic [ADDR_WIDTH-1:0] s1_addr;
   logic [ROW_WIDTH-1:0]  s1_data, s1_old;
   logic                  s2_valid;
   logic [ADDR_WIDTH-1:0] s2_addr;
   logic [ROW_WIDTH-1:0]  s2_sum;
   logic                  s3_valid;
   logic [ADDR_WIDTH-1:0] s3_addr;
   logic [ROW_WIDTH-1:0]  s3_sum;

   logic                  r1_valid;
   logic [ADDR_WIDTH-1:0] r1_addr;

   logic                  wr_in_range, rd_in_range;
   logic [ROW_WIDTH-1:0]  fwd_old, operand, sum_next;
   logic                  sat_next;

   assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIMIT;
   assign rd_in_range = {1'b0, r1_addr} < DEPTH_LIMIT;

   always_comb begin
      logic [WORD_WIDTH-1:0] lane_a, lane_b;
`ifdef ACC_SATURATE_EN
      logic [WORD_WIDTH:0]   wide;
      wide = '0;
`endif
      lane_a   = '0;
      lane_b   = '0;
      sum_next = '0;
      sat_next = 1'b0;
      // Youngest in-flight result to the same row wins over the stale array read.
      if (s2_valid && s2_addr == s1_addr)
         fwd_old = s2_sum;
      else if (s3_valid && s3_addr == s1_addr)
         fwd_old = s3_sum;
      else
         fwd_old = s1_old;
      operand = s1_acc ? fwd_old : '0;
      for (int i = 0; i < MATRIX_WIDTH; i++) begin
         lane_a = s1_data[i*WORD_WIDTH +: WORD_WIDTH];
         lane_b = operand[i*WORD_WIDTH +: WORD_WIDTH];
`ifdef ACC_SATURATE_EN
         wide = {lane_a[WORD_WIDTH-1], lane_a} + {lane_b[WORD_WIDTH-1], lane_b};
         if (wide[WORD_WIDTH] != wide[WORD_WIDTH-1]) begin
            sum_next[i*WORD_WIDTH +: WORD_WIDTH] = wide[WORD_WIDTH] ?
               {1'b1, {(WORD_WIDTH-1){1'b0}}} : {1'b0, {(WORD_WIDTH-1){1'b1}}};
            sat_next = 1'b1;
         end else begin
            sum_next[i*WORD_WIDTH +: WORD_WIDTH] = wide[WORD_WIDTH-1:0];
         end
`else
         sum_next[i*WORD_WIDTH +: WORD_WIDTH] = lane_a + lane_b;
`endif
      end
   end

   // Commit; reset in the same cycle discards the op.
   always_ff @(posedge clk) begin
      if (enable && !rst && s2_valid)
         mem[s2_addr] <= s2_sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         r1_valid <= 1'b0;
         rd_valid <= 1'b0;
         data_out <= '0;
      end else if (enable) begin
         s1_valid <= wr_en && wr_in_range;
         s1_addr  <= wr_addr;
         s1_acc   <= accumulate;
         s1_data  <= data_in;
         if (wr_en && wr_in_range)
            s1_old <= mem[wr_addr];
         s2_valid <= s1_valid;
         s2_addr  <= s1_addr;
         s2_sum   <= sum_next;
         s3_valid <= s2_valid;
         s3_addr  <= s2_addr;
         s3_sum   <= s2_sum;
         r1_valid <= rd_en;
         r1_addr  <= rd_addr;
         rd_valid <= r1_valid;
         // Read-first: a commit on this same edge is not visible here.
         if (r1_valid)
            data_out <= rd_in_range ? mem[r1_addr] : '0;
      end
   end

`ifdef ACC_SATURATE_EN
   logic s2_sat;
   logic sat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_sat <= 1'b0;
         sat_q  <= 1'b0;
      end else if (enable) begin
         s2_sat <= s1_valid && sat_next;
         if (s2_valid && s2_sat)
            sat_q <= 1'b1;
      end
   end

   assign sat_flag = sat_q;
`else
   assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_accumulator_bank.sv
// Bench for accumulator_bank: directed scenarios then random traffic against a sequential
// row model where each write takes effect two enabled edges after it is sampled.
module tb_accumulator_bank;

   localparam int MW    = 4;
   localparam int DEPTH = 300;
   localparam int W     = 8;
   localparam int AW    = $clog2(DEPTH);
   localparam int RW    = MW * W;

   logic          clk = 1'b0;
   logic          rst, enable, wr_en, accumulate, rd_en;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [RW-1:0] data_in;
   logic [RW-1:0] data_out;
   logic          rd_valid, sat_flag;

   accumulator_bank #(
      .MATRIX_WIDTH(MW), .REGISTER_DEPTH(DEPTH), .WORD_WIDTH(W)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
      .accumulate(accumulate), .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr),
      .data_out(data_out), .rd_valid(rd_valid), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic          acc;
      logic [RW-1:0] data;
      int            due;
   } wr_t;

   logic [RW-1:0] mem_m [DEPTH];
   wr_t           pend_w[$];
   logic [RW-1:0] exp_q[$];
   logic          rd_pend;
   logic [AW-1:0] rd_pend_addr;
   logic [RW-1:0] exp_dout;
   logic          exp_rv, exp_sat;
   int            edge_n = 0;
   int            errors = 0;
   int            checks = 0;

   function automatic logic [RW-1:0] fill(input logic [W-1:0] v);
      logic [RW-1:0] r;
      for (int i = 0; i < MW; i++) r[i*W +: W] = v;
      return r;
   endfunction

   function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             output bit sat);
      int s;
      sat = 1'b0;
`ifdef ACC_SATURATE_EN
      s = int'($signed(a)) + int'($signed(b));
      if (s > 2**(W-1) - 1) begin
         s = 2**(W-1) - 1;
         sat = 1'b1;
      end else if (s < -(2**(W-1))) begin
         s = -(2**(W-1));
         sat = 1'b1;
      end
`else
      s = int'(a) + int'(b);
`endif
      return s[W-1:0];
   endfunction

   task automatic commit(input wr_t w);
      logic [RW-1:0] row;
      bit            sat;
      row = mem_m[w.addr];
      for (int i = 0; i < MW; i++) begin
         if (w.acc) begin
            row[i*W +: W] = lane_add(row[i*W +: W], w.data[i*W +: W], sat);
            if (sat) exp_sat = 1'b1;
         end else begin
            row[i*W +: W] = w.data[i*W +: W];
         end
      end
      mem_m[w.addr] = row;
   endtask

   // Called right after each rising edge with the inputs that edge sampled.
   task automatic model_edge();
      if (rst) begin
         pend_w.delete();
         exp_q.delete();
         rd_pend  = 1'b0;
         exp_dout = '0;
         exp_rv   = 1'b0;
         exp_sat  = 1'b0;
         return;
      end
      if (!enable) return;
      exp_rv = rd_pend;
      if (rd_pend) exp_q.push_back((rd_pend_addr < AW'(DEPTH)) ? mem_m[rd_pend_addr] : '0);
      if (pend_w.size() > 0 && pend_w[0].due == edge_n) commit(pend_w.pop_front());
      if (wr_en && wr_addr < AW'(DEPTH))
         pend_w.push_back('{addr: wr_addr, acc: accumulate, data: data_in, due: edge_n + 2});
      rd_pend      = rd_en;
      rd_pend_addr = rd_addr;
      edge_n++;
   endtask

   task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      if (exp_rv && exp_q.size() > 0) exp_dout = exp_q.pop_front();
      chk("data_out", data_out, exp_dout);
      chk("rd_valid", RW'(rd_valid), RW'(exp_rv));
      chk("sat_flag", RW'(sat_flag), RW'(exp_sat));
   endtask

   task automatic cyc(input logic en, input logic we, input logic [AW-1:0] wa, input logic ac,
                      input logic [RW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic r = 1'b0);
      enable = en; wr_en = we; wr_addr = wa; accumulate = ac; data_in = wd;
      rd_en = re; rd_addr = ra; rst = r;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic ac, input logic [RW-1:0] d);
      cyc(1'b1, 1'b1, a, ac, d, 1'b0, '0);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, a);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      rd_pend = 1'b0;
      rd_pend_addr = '0;
      exp_dout = '0; exp_rv = 1'b0; exp_sat = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

      // reset state
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
      chk("reset_dout", data_out, '0);
      chk("reset_rv", RW'(rd_valid), '0);
      chk("reset_sat", RW'(sat_flag), '0);

      // clear every row so the model and array agree
      for (int i = 0; i < DEPTH; i++) wr(AW'(i), 1'b0, '0);
      idle(3);

      // 1: plain write then read
      wr(5, 1'b0, fill(8'd3));
      idle(2);
      rd(5);
      chk("t1_rv_early", RW'(rd_valid), '0);
      idle(1);
      chk("t1_rv", RW'(rd_valid), RW'(1));
      chk("t1_data", data_out, fill(8'd3));
      idle(1);
      chk("t1_rv_drop", RW'(rd_valid), '0);
      chk("t1_hold", data_out, fill(8'd3));

      // 2: back-to-back accumulates, read-first against the final commit
      wr(7, 1'b0, fill(8'd10));
      wr(7, 1'b1, fill(8'd1));
      wr(7, 1'b1, fill(8'd2));
      wr(7, 1'b1, fill(8'd3));
      rd(7);
      idle(1);
      chk("t2_readfirst", data_out, fill(8'd13));
      rd(7);
      idle(1);
      chk("t2_sum", data_out, fill(8'd16));

      // 3: interleaved rows
      for (int k = 0; k < 6; k++) wr((k % 2 == 0) ? AW'(1) : AW'(2), 1'b1, fill(8'd1));
      idle(2);
      rd(1);
      rd(2);
      chk("t3_row1", data_out, fill(8'd3));
      idle(1);
      chk("t3_row2", data_out, fill(8'd3));

      // 4: stall mid-stream with junk requests held on the inputs
      wr(9, 1'b0, fill(8'd5));
      wr(9, 1'b1, fill(8'd1));
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 1'b1, 9, 1'b1, fill(8'hAA), 1'b1, 9);
         chk("t4_stall_rv", RW'(rd_valid), '0);
      end
      wr(9, 1'b1, fill(8'd2));
      wr(9, 1'b1, fill(8'd3));
      idle(2);
      rd(9);
      idle(1);
      chk("t4_sum", data_out, fill(8'd11));

      // 5: out-of-range write/read, then reset kills an op in S1
      wr(AW'(500), 1'b0, fill(8'h55));
      idle(2);
      rd(AW'(500));
      idle(1);
      chk("t5_oor_rv", RW'(rd_valid), RW'(1));
      chk("t5_oor_data", data_out, '0);
      wr(11, 1'b0, fill(8'h77));
      cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
      idle(3);
      rd(11);
      idle(1);
      chk("t5_rst_row", data_out, '0);

      // 6: overflow on accumulate
      wr(20, 1'b0, fill(8'd120));
      wr(20, 1'b1, fill(8'd20));
      idle(2);
      rd(20);
      idle(1);
`ifdef ACC_SATURATE_EN
      chk("t6_sat_flag", RW'(sat_flag), RW'(1));
      chk("t6_data", data_out, fill(8'd127));
`else
      chk("t6_sat_flag", RW'(sat_flag), '0);
      chk("t6_data", data_out, fill(8'h8C));
`endif

      // random traffic concentrated on a few rows to stress forwarding
      for (int k = 0; k < 600; k++) begin
         logic [AW-1:0] wa, ra;
         wa = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(DEPTH, 2**AW - 1))
                                          : AW'($urandom_range(0, 7));
         ra = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(DEPTH, 2**AW - 1))
                                          : AW'($urandom_range(0, 7));
         cyc(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), wa,
             1'($urandom_range(0, 3) != 0), RW'($urandom()), 1'($urandom_range(0, 1)), ra,
             ($urandom_range(0, 127) == 0));
      end
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
